// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the slice-serial CLA arithmetic blocks.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_SLICE = 4;

  function automatic int slice_count(input int width, input int slice);
    return width / slice;
  endfunction

  // Keep at least one bit so a single-slice build still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-look-ahead adder: sum = a + b + cin, with
// every carry built directly from generate/propagate terms rather than rippled.
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE:0]   w_carry;

  assign w_p        = a ^ b;
  assign w_g        = a & b;
  assign w_carry[0] = cin;

  // carry[i+1] = OR of (cin & p[i:0]) and each g[j] & p[i:j+1]
  for (genvar gi = 0; gi < SLICE; gi++) begin : g_carry
    logic [gi+1:0] w_terms;
    assign w_terms[0] = cin & (&w_p[gi:0]);
    for (genvar gj = 0; gj <= gi; gj++) begin : g_term
      if (gj == gi) begin : g_top
        assign w_terms[gj+1] = w_g[gj];
      end else begin : g_mid
        assign w_terms[gj+1] = w_g[gj] & (&w_p[gi:gj+1]);
      end
    end
    assign w_carry[gi+1] = |w_terms;
  end

  assign sum  = w_p ^ w_carry[SLICE-1:0];
  assign cout = w_carry[SLICE];

endmodule

// File: rtl/cla_seq_subtractor.sv
// Slice-serial subtractor: diff = a - b - bin, one CLA slice per clock (LSB first).
// Optional zero/neg flag outputs are enabled by defining CLA_SUB_FLAGS_EN.
module cla_seq_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
`ifdef CLA_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int N  = slice_count(WIDTH, SLICE);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("cla_seq_subtractor: WIDTH must be a multiple of SLICE");
  end

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_bout;
  logic             r_ovf;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_nb_slice;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_last;

  assign w_a_slice  = r_a[int'(r_cnt)*SLICE +: SLICE];
  assign w_nb_slice = ~r_b[int'(r_cnt)*SLICE +: SLICE];
  assign w_last     = (r_cnt == LAST);

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a    (w_a_slice),
    .b    (w_nb_slice),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[int'(r_cnt)*SLICE +: SLICE] = w_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Borrow-in enters as the inverted carry of A + ~B + carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;
            r_diff  <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_diff  <= w_diff_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt  <= '0;
            r_bout <= ~w_cout;
            r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_sum[SLICE-1]);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

`ifdef CLA_SUB_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_zero <= (w_diff_next == '0);
      r_neg  <= w_diff_next[WIDTH-1];
    end
  end

  assign zero = r_zero;
  assign neg  = r_neg;
`endif

endmodule

// File: tb/tb_cla_seq_subtractor.sv
// Directed plus randomized bench for cla_seq_subtractor against an arithmetic model.
module tb_cla_seq_subtractor;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  diff;
  logic          bout;
  logic          ovf;
`ifdef CLA_SUB_FLAGS_EN
  logic          zero;
  logic          neg;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_seq_subtractor #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
`ifdef CLA_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int ua, ub, sa, sb, ud, sd;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ud = ua - ub - int'(mbin);
    sd = sa - sb - int'(mbin);
    ed = W'(ud & 32'hFFFF);
    eb = (ud < 0);
    eo = (sd > 32767) || (sd < -32768);
  endtask

  // Accept one operation, check latency and results, optionally stall in DONE.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input int stall);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           cyc;
    model(oa, ob, obin, ed, eb, eo);
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = oa; b = ob; bin = obin;
    tick();
    in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    chk("latency", 32'(cyc), 32'(LAT));
    chk("diff", 32'(diff), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
    chk("ovf", 32'(ovf), 32'(eo));
`ifdef CLA_SUB_FLAGS_EN
    chk("zero", 32'(zero), 32'(ed == '0));
    chk("neg", 32'(neg), 32'(ed[W-1]));
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_diff", 32'(diff), 32'(ed));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    $display("op a=%04h b=%04h bin=%0d -> diff=%04h bout=%0d ovf=%0d (exp %04h %0d %0d)",
             oa, ob, obin, diff, bout, ovf, ed, eb, eo);
  endtask

  initial begin
    logic [W-1:0] corner [4];
    logic [W-1:0] ra, rb;
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
`ifdef CLA_SUB_FLAGS_EN
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
`endif

    do_op(16'h1234, 16'h0234, 1'b0, 0);
    chk("basic_diff", 32'(diff), 32'h1000);
    do_op(16'h0000, 16'h0001, 1'b0, 0);
    chk("under_diff", 32'(diff), 32'hFFFF);
    chk("under_bout", 32'(bout), 32'd1);
    do_op(16'h0000, 16'h0000, 1'b1, 0);
    chk("under_bin_diff", 32'(diff), 32'hFFFF);
    do_op(16'h8000, 16'h0001, 1'b0, 0);
    chk("ovf1", 32'(ovf), 32'd1);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    chk("ovf2_diff", 32'(diff), 32'h8000);

    // Backpressure: held in DONE with a competing in_valid.
    do_op(16'hABCD, 16'h1111, 1'b1, 3);
    do_op(16'h0100, 16'h0001, 1'b0, 0);
    chk("after_bp_diff", 32'(diff), 32'h00FF);

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1; a = 16'h4444; b = 16'h1111; bin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    $display("reset mid-run: in_ready=%0d out_valid=%0d diff=%04h", in_ready, out_valid, diff);
    do_op(16'h0010, 16'h0001, 1'b0, 0);
    chk("after_rst_diff", 32'(diff), 32'h000F);

`ifdef CLA_SUB_FLAGS_EN
    do_op(16'h5555, 16'h5555, 1'b0, 0);
    chk("flag_zero", 32'(zero), 32'd1);
    do_op(16'h0001, 16'h0002, 1'b0, 0);
    chk("flag_neg", 32'(neg), 32'd1);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_subtractor.md
Name: cla_seq_subtractor

Overview:
Multi-cycle, slice-serial subtractor, the inverse operation of the team's 4-bit carry-look-ahead adder. Computes D = A - B - bin over WIDTH bits by feeding one SLICE-bit CLA per clock with A + ~B + carry.
- Operands are accepted and results returned over valid/ready handshakes.
- Sits in the arithmetic datapath beside the CLA adder and reuses the same CLA slice logic.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of SLICE (elaboration error otherwise)
SLICE, 4, bits processed per clock by the CLA slice

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
diff  output  WIDTH  a - b - bin (mod 2^WIDTH)
bout  output  1  unsigned borrow out (1 when a < b + bin)
ovf  output  1  signed two's-complement overflow

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a rising clk edge): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, internal slice counter=0, carry=0. Reset overrides everything, including mid-RUN and mid-DONE; an in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch a, b, and carry=~bin; clear diff shift register; go to RUN.
  - RUN: in_ready=0. Each cycle, slice k (LSB first) computes {c, s} = a[k] + ~b[k] + carry via CLA generate/propagate. s is written into diff slice k; carry<=c. After N=WIDTH/SLICE RUN cycles, go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready go to IDLE. Until then hold all outputs and keep in_ready=0.
- Latency: out_valid rises exactly N clocks after the acceptance edge (4 for defaults). Throughput is one operation per N+2 cycles minimum; no overlap.
- bout = ~final carry.
- ovf = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), computed on the final RUN cycle.
- diff, bout and ovf are registered. In IDLE they retain the last result; they are only meaningful while out_valid=1.
- in_valid is ignored outside IDLE; operand inputs are don't-care except on the acceptance edge.
- out_valid and out_ready both high in DONE: transfer completes; in_ready=1 on the following cycle (no same-cycle re-accept).
- Wrap-around: result modulo 2^WIDTH (e.g. 0 - 1 = all ones, bout=1).

Optional Feature:
Macro CLA_SUB_FLAGS_EN.
- Defined: adds output ports zero (1 when diff==0) and neg (diff[MSB]). Both are registered with the result, valid with out_valid, and 0 after reset.
- Undefined: ports absent; no flag logic.

Decomposition:
- Package cla_pkg:
  - state enum (IDLE, RUN, DONE)
  - default SLICE constant
  - function computing slice count N=WIDTH/SLICE and counter width
- Sub-module cla_slice: combinational SLICE-bit carry-look-ahead unit (p/g per bit, lookahead carries, sum, carry-out), instantiated once and time-multiplexed across slices.

Test Plan:
- Basic: a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0; out_valid exactly 4 clocks after acceptance.
- Underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Same with bin=1 and b=0 → diff=0xFFFF, bout=1.
- Signed overflow: a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready → in_ready=1 next cycle, and the next operation computes correctly.
- Reset mid-operation: assert rst during the 2nd RUN cycle → next cycle in_ready=1, out_valid=0, diff=0. A following op a=0x0010, b=0x0001 → diff=0x000F.
- With CLA_SUB_FLAGS_EN: a=0x5555, b=0x5555 → zero=1, neg=0. a=0x0001, b=0x0002 → zero=0, neg=1, diff=0xFFFF.
